pkt_width_down_gearbox: RTL

Parametrised wide-to-narrow packet gearbox for the MAC TX path. It accepts wide packet beats with sop/eop and a byte count, and emits them as narrow Avalon-ST-style beats with sop/eop/empty under full ready/valid backpressure. It generalises the fixed 256-to-64-bit TX split to any power-of-two ratio and lane width. It runs in a single clock domain, between the TX crossing FIFO read side and the MAC TX port.

---
 rtl/pkt_width_down_gearbox.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pkt_width_down_gearbox.sv
// Wide-to-narrow packet gearbox: one held wide beat is emitted as up to RATIO
// narrow beats with sop/eop/empty, under full ready/valid backpressure.
module pkt_width_down_gearbox #(
  parameter int NARROW_W = 64,
  parameter int RATIO    = 4,
  localparam int NB = NARROW_W / 8,
  localparam int WB = RATIO * NB,
  localparam int CW = $clog2(WB) + 1,
  localparam int EW = $clog2(NB)
) (
  input  logic                      clock,
  input  logic                      realResetN,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic                      inSop,
  input  logic                      inEop,
  input  logic [CW-1:0]             inByteCount,
  input  logic [RATIO*NARROW_W-1:0] inData,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      outSop,
  output logic                      outEop,
  output logic [EW-1:0]             outEmpty,
  output logic [NARROW_W-1:0]       outData,
  output logic                      outError,
  output logic [31:0]               pktCount,
  output logic [15:0]               errCount
);

  localparam int IW = $clog2(RATIO);
  localparam int SW = IW + 1;

  logic [RATIO*NARROW_W-1:0] hold_data;
  logic                      hold_valid;
  logic                      hold_sop;
  logic                      hold_eop;
  logic                      hold_err;
  logic [SW-1:0]             n_sl;
  logic [EW-1:0]             last_empty;
  logic [IW-1:0]             s_idx;
  logic                      in_pkt;
  logic                      live;

  logic                      last_sl;
  logic                      accept;
  logic                      out_hs;
  logic                      bc_bad;
  logic                      frame_err;
  logic                      beat_err;
  logic [CW-1:0]             bc_eff;
  logic [CW-1:0]             bc_round;
  logic [SW-1:0]             n_sl_new;
  logic [EW-1:0]             last_empty_new;
  logic [NARROW_W-1:0]       slices [RATIO];

  // Slice 0 sits in the MSBs of the wide word.
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign slices[g] = hold_data[(RATIO-1-g)*NARROW_W +: NARROW_W];
  end

  assign last_sl  = ({1'b0, s_idx} == (n_sl - SW'(1)));
  assign inReady  = live & (~hold_valid | (outReady & last_sl));
  assign accept   = inValid & inReady;
  assign out_hs   = hold_valid & outReady;

  assign outValid = hold_valid;
  assign outData  = slices[s_idx];
  assign outSop   = hold_valid & hold_sop & (s_idx == '0);
  assign outEop   = hold_valid & hold_eop & last_sl;
  assign outEmpty = outEop ? last_empty : '0;
  assign outError = hold_valid & hold_err & last_sl;

  // Decode the incoming beat: bad eop byte counts are treated as a full beat.
  always_comb begin
    bc_bad         = inEop & ((inByteCount == '0) | (inByteCount > CW'(WB)));
    bc_eff         = (~inEop | bc_bad) ? CW'(WB) : inByteCount;
    bc_round       = bc_eff + CW'(NB - 1);
    n_sl_new       = SW'(bc_round >> EW);
    last_empty_new = EW'(~bc_eff + CW'(1));
    frame_err      = inSop ? in_pkt : ~in_pkt;
    beat_err       = bc_bad | frame_err;
  end

  // NOTE: every register here is updated with <= so all state samples the
  // pre-edge values together; the held data word is reset too so outData
  // reads 0 after reset rather than stale payload.
  always_ff @(posedge clock or negedge realResetN) begin
    if (!realResetN) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_sop   <= 1'b0;
      hold_eop   <= 1'b0;
      hold_err   <= 1'b0;
      n_sl       <= '0;
      last_empty <= '0;
      s_idx      <= '0;
      in_pkt     <= 1'b0;
      live       <= 1'b0;
      pktCount   <= '0;
      errCount   <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= inData;
        hold_sop   <= inSop;
        hold_eop   <= inEop;
        hold_err   <= beat_err;
        n_sl       <= n_sl_new;
        last_empty <= last_empty_new;
        s_idx      <= '0;
        if (inEop)      in_pkt <= 1'b0;
        else if (inSop) in_pkt <= 1'b1;
        if (beat_err && (errCount != 16'hFFFF)) errCount <= errCount + 16'd1;
      end else if (out_hs) begin
        if (last_sl) hold_valid <= 1'b0;
        else         s_idx      <= s_idx + 1'b1;
      end
      if (out_hs && hold_eop && last_sl) pktCount <= pktCount + 32'd1;
    end
  end

endmodule
